// File: rtl/xor_pkg.sv
// Shared widths and types for the registered XOR slice.
package xor_pkg;

  localparam int XOR_WIDTH = 32;
  localparam int ONES_W    = $clog2(XOR_WIDTH + 1);

  typedef logic [XOR_WIDTH-1:0] word_t;
  typedef logic [ONES_W-1:0]    ones_t;

endpackage

// File: rtl/xor_32_popcount32.sv
// Combinational adder tree counting set bits of a 32-bit word.
// Five levels: 1b+1b, 2b+2b, 3b+3b, 4b+4b, 5b+5b.
module popcount32
  import xor_pkg::*;
(
  input  word_t word,
  output ones_t count
);

  logic [1:0] l1 [16];
  logic [2:0] l2 [8];
  logic [3:0] l3 [4];
  logic [4:0] l4 [2];

  genvar i;

  generate
    for (i = 0; i < 16; i++) begin : g_l1
      assign l1[i] = {1'b0, word[2*i]}
                   + {1'b0, word[2*i+1]};
    end

    for (i = 0; i < 8; i++) begin : g_l2
      assign l2[i] = {1'b0, l1[2*i]}
                   + {1'b0, l1[2*i+1]};
    end

    for (i = 0; i < 4; i++) begin : g_l3
      assign l3[i] = {1'b0, l2[2*i]}
                   + {1'b0, l2[2*i+1]};
    end

    for (i = 0; i < 2; i++) begin : g_l4
      assign l4[i] = {1'b0, l3[2*i]}
                   + {1'b0, l3[2*i+1]};
    end
  endgenerate

  assign count = {1'b0, l4[0]}
               + {1'b0, l4[1]};

endmodule

// File: rtl/xor_32.sv
// Registered bitwise XOR with zero, parity and popcount flags.
// One-cycle latency, one result per clock, no backpressure.
module xor_32
  import xor_pkg::*;
#(
  parameter int WIDTH = XOR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             parity,
  output logic [5:0]       ones
);

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_par;
  ones_t            res_ones;

  assign res      = a ^ b;
  assign res_par  = ^res;
  assign res_zero = (res == '0);

  popcount32 u_pop (
    .word  (word_t'(res)),
    .count (res_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      ones      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y      <= res;
        zero   <= res_zero;
        parity <= res_par;
        ones   <= res_ones;
      end
    end
  end

endmodule

// File: tb/tb_xor_32.sv
// Randomized self-checking bench for xor_32 against a behavioural model.
module tb_xor_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        out_valid;
  logic        zero;
  logic        parity;
  logic [5:0]  ones;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_y;
  logic        m_ov;
  logic        m_z;
  logic        m_p;
  int          m_o;

  xor_32 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid),
    .zero      (zero),
    .parity    (parity),
    .ones      (ones)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  function automatic int pop(input logic [31:0] v);
    int c = 0;
    for (int k = 0; k < 32; k++)
      c += int'((v >> k) & 32'd1);
    return c;
  endfunction

  task automatic model_reset();
    m_y  = '0;
    m_ov = 1'b0;
    m_z  = 1'b0;
    m_p  = 1'b0;
    m_o  = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y"}, y, m_y);
    chk({tag, ".ov"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".zero"}, 32'(zero), 32'(m_z));
    chk({tag, ".par"}, 32'(parity), 32'(m_p));
    chk({tag, ".ones"}, 32'(ones), 32'(m_o));
  endtask

  task automatic step(input logic [31:0] sa,
                      input logic [31:0] sb,
                      input logic        sv,
                      input string       tag);
    logic [31:0] r;
    @(negedge clk);
    a        = sa;
    b        = sb;
    in_valid = sv;
    @(posedge clk);
    #1;
    m_ov = sv;
    if (sv) begin
      r   = sa ^ sb;
      m_y = r;
      m_o = pop(r);
      m_p = (m_o % 2) == 1;
      m_z = (m_o == 0);
    end
    // Disturb operands between edges; outputs must not move.
    a = $urandom;
    b = $urandom;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    step(32'd4, 32'd2, 1'b1, "first");
    chk("first_y_const", y, 32'h0000_0006);
    chk("first_ones_const", 32'(ones), 32'd2);

    async_reset("async_rst");
    step(32'd4, 32'd2, 1'b1, "post_rst");

    step(-32'sd4, -32'sd4, 1'b1, "equal");
    chk("equal_zero_const", 32'(zero), 32'd1);

    for (int i = -4; i <= 4; i++)
      for (int j = -4; j <= 4; j++)
        step(32'(i), 32'(j), 1'b1, "sweep");

    step(-32'sd4, 32'd4, 1'b1, "spot1");
    chk("spot1_y", y, 32'hFFFF_FFF8);
    chk("spot1_ones", 32'(ones), 32'd29);
    step(32'd3, -32'sd3, 1'b1, "spot2");
    chk("spot2_y", y, 32'hFFFF_FFFE);
    chk("spot2_par", 32'(parity), 32'd1);
    step(32'd0, -32'sd4, 1'b1, "spot3");
    chk("spot3_ones", 32'(ones), 32'd30);

    step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, "alt");
    chk("alt_ones", 32'(ones), 32'd32);
    chk("alt_par", 32'(parity), 32'd0);
    step(32'h8000_0000, 32'd0, 1'b1, "msb");
    chk("msb_ones", 32'(ones), 32'd1);

    step(32'd1, 32'd2, 1'b1, "hold_acc");
    for (int k = 0; k < 5; k++) begin
      step($urandom, $urandom, 1'b0, "hold");
      chk("hold_y_const", y, 32'h0000_0003);
    end

    for (int k = 0; k < 300; k++) begin
      logic [31:0] ra;
      ra = $urandom;
      case (k % 4)
        0: step(ra, ra, 1'b1, "rnd_aa");
        1: step(ra, ~ra, 1'b1, "rnd_not");
        2: step(ra, 32'd0, 1'b1, "rnd_zero");
        default:
          step(ra, $urandom, ($urandom_range(3) != 0), "rnd");
      endcase
    end

    for (int k = 0; k < 4; k++)
      step($urandom, $urandom, 1'b1, "stream");
    async_reset("mid_rst");
    step(32'h0F0F_0000, 32'h0000_F0F1, 1'b1, "after_rst");
    chk("after_rst_ones", 32'(ones), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
